control_32: RTL and testbench

CONTROL_32 -- requirements
Module: control_32

---
 rtl/control_32_pkg.sv | 53 +++++
 rtl/control_32_decode.sv | 62 ++++++
 rtl/control_32.sv | 87 ++++++++
 tb/tb_control_32.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/control_32_pkg.sv
// Shared opcode constants and control-field encodings for the
// single-cycle main decoder.
package control_32_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } mem_toreg_e;

    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_RA   = 2'b10,
        DST_RSVD = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        JMP_SEQ   = 2'b00,
        JMP_TGT   = 2'b01,
        JMP_RSVD2 = 2'b10,
        JMP_RSVD3 = 2'b11
    } jump_e;

    typedef struct packed {
        logic       reg_write;
        reg_dst_e   reg_dst;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        mem_toreg_e mem_toreg;
        jump_e      jump;
        alu_op_e    alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_32_decode.sv
// Purely combinational opcode-to-control table; flags any opcode
// outside the table as illegal with all controls forced low.
module control_32_decode
    import control_32_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_ADDI  = OPC_ADDI,
    parameter logic [5:0] OP_J     = OPC_J,
    parameter logic [5:0] OP_JAL   = OPC_JAL
) (
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        unique case (1'b1)
            (opcode == OP_RTYPE): begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = DST_RD;
                ctrl.alu_op    = ALU_FUNCT;
            end
            (opcode == OP_LW): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.mem_toreg = WB_MEM;
                ctrl.alu_op    = ALU_ADD;
            end
            (opcode == OP_SW): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            (opcode == OP_BEQ): begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            (opcode == OP_ADDI): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            (opcode == OP_J): begin
                ctrl.jump = JMP_TGT;
            end
            (opcode == OP_JAL): begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = DST_RA;
                ctrl.mem_toreg = WB_PC4;
                ctrl.jump      = JMP_TGT;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_32.sv
// Main control unit: combinational decode plus sticky error flag,
// saturating illegal-opcode counter and last-illegal-opcode capture.
module control_32 #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_JAL   = 6'b000011,
    parameter int          CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             instr_valid,
    input  logic             err_clear,
    output logic [1:0]       alu_op,
    output logic [1:0]       mem_toreg,
    output logic             mem_write,
    output logic             mem_read,
    output logic             branch,
    output logic             alu_src,
    output logic [1:0]       reg_dst,
    output logic             reg_write,
    output logic [1:0]       jump,
    output logic             err_illegal_opcode,
    output logic             err_sticky,
    output logic [CNT_W-1:0] illegal_count,
    output logic [5:0]       last_illegal_opcode
);

    import control_32_pkg::*;

    localparam logic [5:0] lw   = OP_LW;
    localparam logic [5:0] sw   = OP_SW;
    localparam logic [5:0] beq  = OP_BEQ;
    localparam logic [5:0] addi = OP_ADDI;
    localparam logic [5:0] j    = OP_J;
    localparam logic [5:0] jal  = OP_JAL;

    ctrl_t ctrl;
    logic  illegal;

    control_32_decode #(
        .OP_RTYPE (OP_RTYPE),
        .OP_LW    (lw),
        .OP_SW    (sw),
        .OP_BEQ   (beq),
        .OP_ADDI  (addi),
        .OP_J     (j),
        .OP_JAL   (jal)
    ) u_decode (
        .opcode  (opcode),
        .ctrl    (ctrl),
        .illegal (illegal)
    );

    assign alu_op             = ctrl.alu_op;
    assign mem_toreg          = ctrl.mem_toreg;
    assign mem_write          = ctrl.mem_write;
    assign mem_read           = ctrl.mem_read;
    assign branch             = ctrl.branch;
    assign alu_src            = ctrl.alu_src;
    assign reg_dst            = ctrl.reg_dst;
    assign reg_write          = ctrl.reg_write;
    assign jump               = ctrl.jump;
    assign err_illegal_opcode = illegal;

    // Clear beats a same-cycle illegal event; the capture is not cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky          <= 1'b0;
            illegal_count       <= '0;
            last_illegal_opcode <= '0;
        end else if (err_clear) begin
            err_sticky    <= 1'b0;
            illegal_count <= '0;
        end else if (instr_valid && illegal) begin
            err_sticky          <= 1'b1;
            last_illegal_opcode <= opcode;
            if (illegal_count != {CNT_W{1'b1}})
                illegal_count <= illegal_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_control_32.sv
// Directed-vector bench for control_32: decode table, illegal
// opcodes, counter saturation, clear and reset priority.
module tb_control_32;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       instr_valid;
    logic       err_clear;
    logic [1:0] alu_op;
    logic [1:0] mem_toreg;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] jump;
    logic       err_illegal_opcode;
    logic       err_sticky;
    logic [7:0] illegal_count;
    logic [5:0] last_illegal_opcode;

    int n_chk  = 0;
    int n_pass = 0;

    control_32 dut (
        .clk                 (clk),
        .rst                 (rst),
        .opcode              (opcode),
        .instr_valid         (instr_valid),
        .err_clear           (err_clear),
        .alu_op              (alu_op),
        .mem_toreg           (mem_toreg),
        .mem_write           (mem_write),
        .mem_read            (mem_read),
        .branch              (branch),
        .alu_src             (alu_src),
        .reg_dst             (reg_dst),
        .reg_write           (reg_write),
        .jump                (jump),
        .err_illegal_opcode  (err_illegal_opcode),
        .err_sticky          (err_sticky),
        .illegal_count       (illegal_count),
        .last_illegal_opcode (last_illegal_opcode)
    );

    always #5 clk = ~clk;

    logic [10:0] vec;
    assign vec = {reg_write, reg_dst, alu_src, branch, mem_write,
                  mem_read, mem_toreg, jump};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  ok_op  [7] = '{6'b000000, 6'b100011, 6'b101011,
                                6'b000100, 6'b001000, 6'b000010,
                                6'b000011};
    logic [10:0] ok_vec [7] = '{11'b10100000000, 11'b10010010100,
                                11'b00010100000, 11'b00001000000,
                                11'b10010000000, 11'b00000000001,
                                11'b11000001001};
    logic [1:0]  ok_alu [7] = '{2'b10, 2'b00, 2'b00, 2'b01,
                                2'b00, 2'b00, 2'b00};
    logic [5:0]  bad_op [6] = '{6'b001110, 6'b111111, 6'b111011,
                                6'b011110, 6'b111010, 6'b100111};

    initial begin
        rst = 1'b1;
        opcode = 6'b000000;
        instr_valid = 1'b0;
        err_clear = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_sticky", 32'(err_sticky), 32'd0);
        chk("rst_count", 32'(illegal_count), 32'd0);
        chk("rst_last", 32'(last_illegal_opcode), 32'd0);

        for (int i = 0; i < 7; i++) begin
            opcode = ok_op[i];
            #1;
            chk($sformatf("vec_%b", ok_op[i]), 32'(vec), 32'(ok_vec[i]));
            chk($sformatf("alu_%b", ok_op[i]), 32'(alu_op), 32'(ok_alu[i]));
            chk($sformatf("err_%b", ok_op[i]), 32'(err_illegal_opcode), 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            opcode = bad_op[i];
            #1;
            chk($sformatf("vec_%b", bad_op[i]), 32'(vec), 32'd0);
            chk($sformatf("alu_%b", bad_op[i]), 32'(alu_op), 32'd0);
            chk($sformatf("err_%b", bad_op[i]), 32'(err_illegal_opcode), 32'd1);
        end
        step();
        chk("idle_count", 32'(illegal_count), 32'd0);

        instr_valid = 1'b1;
        opcode = 6'b001110;
        step();
        opcode = 6'b111111;
        step();
        opcode = 6'b111010;
        step();
        instr_valid = 1'b0;
        chk("three_count", 32'(illegal_count), 32'd3);
        chk("three_sticky", 32'(err_sticky), 32'd1);
        chk("three_last", 32'(last_illegal_opcode), 32'h3a);

        opcode = 6'b100111;
        #1;
        chk("inv_err", 32'(err_illegal_opcode), 32'd1);
        step();
        chk("inv_count", 32'(illegal_count), 32'd3);
        chk("inv_last", 32'(last_illegal_opcode), 32'h3a);

        instr_valid = 1'b1;
        opcode = 6'b100011;
        step();
        chk("legal_count", 32'(illegal_count), 32'd3);

        instr_valid = 1'b0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("clr_count", 32'(illegal_count), 32'd0);
        chk("clr_sticky", 32'(err_sticky), 32'd0);
        chk("clr_last", 32'(last_illegal_opcode), 32'h3a);

        instr_valid = 1'b1;
        opcode = 6'b111011;
        for (int i = 0; i < 300; i++) step();
        chk("sat_count", 32'(illegal_count), 32'd255);
        chk("sat_sticky", 32'(err_sticky), 32'd1);
        chk("sat_last", 32'(last_illegal_opcode), 32'h3b);

        opcode = 6'b011110;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("clrwin_count", 32'(illegal_count), 32'd0);
        chk("clrwin_sticky", 32'(err_sticky), 32'd0);
        chk("clrwin_last", 32'(last_illegal_opcode), 32'h3b);

        opcode = 6'b001110;
        step();
        chk("pre_rst_count", 32'(illegal_count), 32'd1);

        rst = 1'b1;
        err_clear = 1'b1;
        opcode = 6'b111111;
        step();
        chk("rstwin_sticky", 32'(err_sticky), 32'd0);
        chk("rstwin_count", 32'(illegal_count), 32'd0);
        chk("rstwin_last", 32'(last_illegal_opcode), 32'd0);
        opcode = 6'b100011;
        #1;
        chk("rst_dec_vec", 32'(vec), 32'(11'b10010010100));
        rst = 1'b0;
        err_clear = 1'b0;
        instr_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
